// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the frame builder state type.
// Shared by the transmit framer and the later receive path.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;
    localparam int          ETH_MIN_LEN  = 60;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG
    } eth_fb_state_t;

endpackage

// File: rtl/eth_crc32.sv
// Byte-wide IEEE 802.3 CRC-32 next-state function (reflected, LSB first).
// Purely combinational.
module eth_crc32
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    logic [31:0] c;

    always_comb begin
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_next = c;
    end

endmodule

// File: rtl/eth_frame_builder.sv
// Wire-byte framer: preamble, SFD, frame, pad, FCS, then inter-frame gap.
// Zero padding to MIN_LEN exists only with ETH_FRAME_BUILDER_PAD_EN defined.
module eth_frame_builder
    import eth_pkg::*;
#(
    parameter int MIN_LEN    = ETH_MIN_LEN,
    parameter int IFG_CYCLES = 192
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic       busy
);

    localparam int IW = $clog2(IFG_CYCLES + 1);

    eth_fb_state_t state, state_n;
    logic [7:0]    out_data_n;
    logic          out_valid_n, out_last_n;
    logic [31:0]   crc, crc_n, crc_upd;
    logic [10:0]   cnt, cnt_n, cnt_inc;
    logic [2:0]    pre_cnt, pre_cnt_n;
    logic [1:0]    fcs_idx, fcs_idx_n;
    logic [IW-1:0] ifg_cnt, ifg_cnt_n;
    logic [7:0]    crc_byte, fcs_byte;
    logic [31:0]   crc_inv;
    logic          adv, take;

    eth_crc32 u_crc (
        .crc      (crc),
        .data     (crc_byte),
        .crc_next (crc_upd)
    );

    assign adv      = !out_valid | out_ready;
    assign in_ready = (state == DATA) & adv;
    assign take     = in_valid & in_ready;
    assign busy     = (state != IDLE);
    assign crc_byte = (state == DATA) ? in_data : 8'h00;
    assign cnt_inc  = (cnt == 11'h7FF) ? cnt : cnt + 11'd1;
    assign crc_inv  = ~crc;

`ifdef ETH_FRAME_BUILDER_PAD_EN
    logic short_frm;
    assign short_frm = ({1'b0, cnt} + 12'd1) < 12'(MIN_LEN);
`endif

    always_comb begin
        unique case (fcs_idx)
            2'd0:    fcs_byte = crc_inv[7:0];
            2'd1:    fcs_byte = crc_inv[15:8];
            2'd2:    fcs_byte = crc_inv[23:16];
            default: fcs_byte = crc_inv[31:24];
        endcase
    end

    always_comb begin
        state_n     = state;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        out_last_n  = out_last;
        crc_n       = crc;
        cnt_n       = cnt;
        pre_cnt_n   = pre_cnt;
        fcs_idx_n   = fcs_idx;
        ifg_cnt_n   = ifg_cnt;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    out_data_n  = ETH_PREAMBLE;
                    out_valid_n = 1'b1;
                    pre_cnt_n   = 3'd1;
                    state_n     = PRE;
                end
            end
            PRE: begin
                if (adv) begin
                    if (pre_cnt == 3'd7) begin
                        out_data_n = ETH_SFD;
                        state_n    = SFD;
                    end else begin
                        out_data_n = ETH_PREAMBLE;
                        pre_cnt_n  = pre_cnt + 3'd1;
                    end
                end
            end
            SFD: begin
                if (adv) begin
                    out_valid_n = 1'b0;
                    crc_n       = ETH_CRC_INIT;
                    cnt_n       = 11'd0;
                    fcs_idx_n   = 2'd0;
                    state_n     = DATA;
                end
            end
            DATA: begin
                if (take) begin
                    out_data_n  = in_data;
                    out_valid_n = 1'b1;
                    crc_n       = crc_upd;
                    cnt_n       = cnt_inc;
                    if (in_last) begin
`ifdef ETH_FRAME_BUILDER_PAD_EN
                        state_n = short_frm ? PAD : FCS;
`else
                        state_n = FCS;
`endif
                    end
                end else if (adv) begin
                    out_valid_n = 1'b0;
                end
            end
`ifdef ETH_FRAME_BUILDER_PAD_EN
            PAD: begin
                if (adv) begin
                    out_data_n  = 8'h00;
                    out_valid_n = 1'b1;
                    crc_n       = crc_upd;
                    cnt_n       = cnt_inc;
                    if (!short_frm) state_n = FCS;
                end
            end
`endif
            FCS: begin
                // The byte on the output when entering FCS is the final data/pad byte.
                if (adv) begin
                    if (out_last) begin
                        out_valid_n = 1'b0;
                        out_last_n  = 1'b0;
                        ifg_cnt_n   = '0;
                        state_n     = IFG;
                    end else begin
                        out_data_n  = fcs_byte;
                        out_valid_n = 1'b1;
                        out_last_n  = (fcs_idx == 2'd3);
                        fcs_idx_n   = fcs_idx + 2'd1;
                    end
                end
            end
            IFG: begin
                if (ifg_cnt == IW'(IFG_CYCLES - 1)) state_n = IDLE;
                else ifg_cnt_n = ifg_cnt + IW'(1);
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            out_data  <= 8'h00;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            crc       <= ETH_CRC_INIT;
            cnt       <= 11'd0;
            pre_cnt   <= 3'd0;
            fcs_idx   <= 2'd0;
            ifg_cnt   <= '0;
        end else begin
            state     <= state_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
            out_last  <= out_last_n;
            crc       <= crc_n;
            cnt       <= cnt_n;
            pre_cnt   <= pre_cnt_n;
            fcs_idx   <= fcs_idx_n;
            ifg_cnt   <= ifg_cnt_n;
        end
    end

endmodule
